// File: rtl/rvh_l1d_ar_arbiter.sv
// Round-robin arbiter sharing the L2 AR channel among L1D MSHR banks, with per-bank
// outstanding-read limiting and a one-entry registered output stage.
module rvh_l1d_ar_arbiter #(
   parameter int unsigned N_BANK   = 4,
   parameter int unsigned N_BANK_W = $clog2(N_BANK),
   parameter int unsigned MAX_OUTS = 8,
   parameter int unsigned OUTS_W   = $clog2(MAX_OUTS + 1),
   // Width of the flattened cache_mem_if_ar_t payload (arid, araddr, ...).
   parameter int unsigned AR_W     = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_BANK-1:0]             bank_arvalid_i,
   input  logic [N_BANK-1:0][AR_W-1:0]   bank_ar_i,
   output logic [N_BANK-1:0]             bank_arready_o,
   output logic                          l2_arvalid_o,
   input  logic                          l2_arready_i,
   output logic [AR_W-1:0]               l2_ar_o,
   input  logic                          rd_done_valid_i,
   input  logic [N_BANK_W-1:0]           rd_done_bank_i,
   output logic [N_BANK-1:0][OUTS_W-1:0] outs_cnt_o
);

   logic [N_BANK_W-1:0]             ptr_q, ptr_d;
   logic [N_BANK_W-1:0]             gnt_idx, cand;
   logic                            gnt_vld;
   logic                            stage_free;
   logic [N_BANK-1:0]               eligible;
   logic [N_BANK-1:0]               inc, dec;
   logic [N_BANK-1:0][OUTS_W-1:0]   cnt_q, cnt_d;
   logic                            ar_vld_q, ar_vld_d;
   logic [AR_W-1:0]                 ar_q, ar_d;

   assign stage_free     = ~ar_vld_q | l2_arready_i;
   assign l2_arvalid_o   = ar_vld_q;
   assign l2_ar_o        = ar_q;
   assign outs_cnt_o     = cnt_q;

   always_comb begin
      for (int unsigned b = 0; b < N_BANK; b++) begin
         eligible[b] = bank_arvalid_i[b] & (cnt_q[b] != OUTS_W'(MAX_OUTS));
      end
   end

   // Search upward from ptr_q, wrapping; the first eligible bank wins.
   always_comb begin
      gnt_vld        = 1'b0;
      gnt_idx        = '0;
      cand           = '0;
      bank_arready_o = '0;
      if (stage_free) begin
         for (int unsigned i = 0; i < N_BANK; i++) begin
            cand = N_BANK_W'((32'(ptr_q) + i) % N_BANK);
            if (!gnt_vld && eligible[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (gnt_vld) begin
         bank_arready_o[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) begin
         ptr_d = (32'(gnt_idx) == N_BANK - 1) ? '0 : gnt_idx + N_BANK_W'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      inc   = '0;
      dec   = '0;
      for (int unsigned b = 0; b < N_BANK; b++) begin
         inc[b] = gnt_vld && (gnt_idx == N_BANK_W'(b));
         dec[b] = rd_done_valid_i && (rd_done_bank_i == N_BANK_W'(b));
         if (inc[b] && !dec[b]) begin
            cnt_d[b] = cnt_q[b] + OUTS_W'(1);
         end else if (dec[b] && !inc[b] && (cnt_q[b] != '0)) begin
            cnt_d[b] = cnt_q[b] - OUTS_W'(1);
         end
      end
   end

   always_comb begin
      ar_vld_d = ar_vld_q;
      ar_d     = ar_q;
      if (gnt_vld) begin
         ar_vld_d = 1'b1;
         ar_d     = bank_ar_i[gnt_idx];
      end else if (l2_arready_i) begin
         ar_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q    <= '0;
         cnt_q    <= '0;
         ar_vld_q <= 1'b0;
         ar_q     <= '0;
      end else begin
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         ar_vld_q <= ar_vld_d;
         ar_q     <= ar_d;
      end
   end

`ifndef SYNTHESIS
   a_arready_onehot0: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(bank_arready_o));

   a_l2_ar_stable: assert property (@(posedge clk) disable iff (!rst)
      (l2_arvalid_o && !l2_arready_i) |=> (l2_arvalid_o && $stable(l2_ar_o)));

   a_rd_done_bank_range: assert property (@(posedge clk) disable iff (!rst)
      rd_done_valid_i |-> (32'(rd_done_bank_i) < N_BANK));

   // A completion with nothing outstanding is a bank-side bug; counter saturates at 0.
   always @(posedge clk) begin
      if (rst && rd_done_valid_i) begin
         a_rd_done_underflow: assert (cnt_q[rd_done_bank_i] != '0)
            else $warning("rd_done with zero outstanding on bank %0d", rd_done_bank_i);
      end
   end
`endif

endmodule

// File: tb/tb_rvh_l1d_ar_arbiter.sv
// Self-checking bench for rvh_l1d_ar_arbiter: directed scenarios with a payload scoreboard
// pushed on bank grant and popped on the L2 AR handshake.
module tb_rvh_l1d_ar_arbiter;

   localparam int NB = 4;
   localparam int MO = 8;
   localparam int AW = 64;
   localparam int OW = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NB-1:0]          bank_arvalid;
   logic [NB-1:0][AW-1:0]  bank_ar;
   logic [NB-1:0]          bank_arready;
   logic                   l2_arvalid;
   logic                   l2_arready;
   logic [AW-1:0]          l2_ar;
   logic                   rd_done_valid;
   logic [1:0]             rd_done_bank;
   logic [NB-1:0][OW-1:0]  outs_cnt;

   int checks   = 0;
   int failures = 0;
   logic [AW-1:0] exp_q [$];

   rvh_l1d_ar_arbiter #(
      .N_BANK   (NB),
      .MAX_OUTS (MO),
      .AR_W     (AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .bank_arvalid_i  (bank_arvalid),
      .bank_ar_i       (bank_ar),
      .bank_arready_o  (bank_arready),
      .l2_arvalid_o    (l2_arvalid),
      .l2_arready_i    (l2_arready),
      .l2_ar_o         (l2_ar),
      .rd_done_valid_i (rd_done_valid),
      .rd_done_bank_i  (rd_done_bank),
      .outs_cnt_o      (outs_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] mk_ar(int b, int n);
      return {16'(b), 16'(n), 32'h8000_0000 + 32'(n * 64)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bank_arvalid  = '0;
      bank_ar       = '0;
      l2_arready    = 1'b0;
      rd_done_valid = 1'b0;
      rd_done_bank  = '0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      drive_idle();
      #1;
      rst = 1'b0;
      #2;
      checks++; if (l2_arvalid !== 1'b0) begin failures++;
         $display("FAIL reset_arvalid: got %b want 0", l2_arvalid); end
      checks++; if (l2_ar !== '0) begin failures++;
         $display("FAIL reset_ar: got %h want 0", l2_ar); end
      checks++; if (outs_cnt !== '0) begin failures++;
         $display("FAIL reset_cnt: got %h want 0", outs_cnt); end
      checks++; if (bank_arready !== '0) begin failures++;
         $display("FAIL reset_arready: got %b want 0000", bank_arready); end
      @(negedge clk);
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      logic [AW-1:0] want;
      reset_dut();
      bank_ar[2]   = {32'h0002_0000, 32'h8000_0040};
      bank_arvalid = 4'b0100;
      l2_arready   = 1'b1;
      #1;
      checks++; if (bank_arready !== 4'b0100) begin failures++;
         $display("FAIL single_grant: got %b want 0100", bank_arready); end
      checks++; if (l2_arvalid !== 1'b0) begin failures++;
         $display("FAIL single_empty: got %b want 0", l2_arvalid); end
      exp_q.push_back({32'h0002_0000, 32'h8000_0040});
      cyc();
      bank_arvalid = 4'b1111;
      for (int b = 0; b < NB; b++) bank_ar[b] = mk_ar(b, 1);
      #1;
      checks++; if (l2_arvalid !== 1'b1) begin failures++;
         $display("FAIL single_valid: got %b want 1", l2_arvalid); end
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_ar !== want) begin failures++;
         $display("FAIL single_payload: got %h want %h", l2_ar, want); end
      checks++; if (l2_ar[31:0] !== 32'h8000_0040) begin failures++;
         $display("FAIL single_addr: got %h want 80000040", l2_ar[31:0]); end
      checks++; if (outs_cnt[2] !== 4'd1) begin failures++;
         $display("FAIL single_cnt2: got %0d want 1", outs_cnt[2]); end
      checks++; if (bank_arready !== 4'b1000) begin failures++;
         $display("FAIL single_ptr3: got %b want 1000", bank_arready); end
      exp_q.push_back(mk_ar(3, 1));
      cyc();
      bank_arvalid = '0;
      #1;
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_arvalid !== 1'b1 || l2_ar !== want) begin failures++;
         $display("FAIL single_payload3: got %b/%h want 1/%h", l2_arvalid, l2_ar, want); end
      checks++; if (outs_cnt[3] !== 4'd1) begin failures++;
         $display("FAIL single_cnt3: got %0d want 1", outs_cnt[3]); end
      cyc();
      checks++; if (l2_arvalid !== 1'b0) begin failures++;
         $display("FAIL single_drain: got %b want 0", l2_arvalid); end
   endtask

   task automatic test_round_robin();
      logic [AW-1:0] want;
      reset_dut();
      l2_arready   = 1'b1;
      bank_arvalid = '1;
      for (int k = 0; k < 6; k++) begin
         for (int b = 0; b < NB; b++) bank_ar[b] = mk_ar(b, k);
         #1;
         checks++; if (bank_arready !== 4'(1 << (k % NB))) begin failures++;
            $display("FAIL rr_grant[%0d]: got %b want %b", k, bank_arready, 4'(1 << (k % NB)));
         end
         exp_q.push_back(mk_ar(k % NB, k));
         if (k > 0) begin
            if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
            checks++; if (l2_arvalid !== 1'b1 || l2_ar !== want) begin failures++;
               $display("FAIL rr_payload[%0d]: got %b/%h want 1/%h", k, l2_arvalid, l2_ar,
                        want); end
         end
         cyc();
      end
      bank_arvalid = '0;
      #1;
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_arvalid !== 1'b1 || l2_ar !== want) begin failures++;
         $display("FAIL rr_payload_last: got %b/%h want 1/%h", l2_arvalid, l2_ar, want); end
      checks++; if (outs_cnt !== {4'd1, 4'd1, 4'd2, 4'd2}) begin failures++;
         $display("FAIL rr_counts: got %h want 1122", outs_cnt); end
      cyc();
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] want;
      reset_dut();
      l2_arready   = 1'b0;
      bank_ar[0]   = mk_ar(0, 10);
      bank_ar[1]   = mk_ar(1, 10);
      bank_arvalid = 4'b0011;
      #1;
      checks++; if (bank_arready !== 4'b0001) begin failures++;
         $display("FAIL bp_first_grant: got %b want 0001", bank_arready); end
      exp_q.push_back(mk_ar(0, 10));
      cyc();
      bank_ar[0] = mk_ar(0, 11);
      for (int h = 0; h < 5; h++) begin
         #1;
         checks++; if (l2_arvalid !== 1'b1 || l2_ar !== mk_ar(0, 10)) begin failures++;
            $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", h, l2_arvalid, l2_ar,
                     mk_ar(0, 10)); end
         checks++; if (bank_arready !== '0) begin failures++;
            $display("FAIL bp_noready[%0d]: got %b want 0000", h, bank_arready); end
         cyc();
      end
      l2_arready = 1'b1;
      #1;
      checks++; if (bank_arready !== 4'b0010) begin failures++;
         $display("FAIL bp_passthru: got %b want 0010", bank_arready); end
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_ar !== want) begin failures++;
         $display("FAIL bp_payload0: got %h want %h", l2_ar, want); end
      exp_q.push_back(mk_ar(1, 10));
      cyc();
      bank_arvalid = '0;
      #1;
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_arvalid !== 1'b1 || l2_ar !== want) begin failures++;
         $display("FAIL bp_payload1: got %b/%h want 1/%h", l2_arvalid, l2_ar, want); end
      cyc();
      checks++; if (l2_arvalid !== 1'b0) begin failures++;
         $display("FAIL bp_drain: got %b want 0", l2_arvalid); end
   endtask

   task automatic test_outstanding_limit();
      logic [AW-1:0] want;
      reset_dut();
      l2_arready   = 1'b1;
      bank_arvalid = 4'b1000;
      for (int k = 0; k < MO; k++) begin
         bank_ar[3] = mk_ar(3, k);
         #1;
         checks++; if (bank_arready !== 4'b1000) begin failures++;
            $display("FAIL lim_grant[%0d]: got %b want 1000", k, bank_arready); end
         exp_q.push_back(mk_ar(3, k));
         if (k > 0) begin
            if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
            checks++; if (l2_ar !== want) begin failures++;
               $display("FAIL lim_payload[%0d]: got %h want %h", k, l2_ar, want); end
         end
         cyc();
      end
      #1;
      checks++; if (bank_arready !== '0) begin failures++;
         $display("FAIL lim_blocked: got %b want 0000", bank_arready); end
      checks++; if (outs_cnt[3] !== 4'd8) begin failures++;
         $display("FAIL lim_cnt_full: got %0d want 8", outs_cnt[3]); end
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_ar !== want) begin failures++;
         $display("FAIL lim_payload_last: got %h want %h", l2_ar, want); end
      cyc();
      checks++; if (l2_arvalid !== 1'b0) begin failures++;
         $display("FAIL lim_drain: got %b want 0", l2_arvalid); end
      rd_done_valid = 1'b1;
      rd_done_bank  = 2'd3;
      bank_ar[3]    = mk_ar(3, 8);
      #1;
      checks++; if (bank_arready !== '0) begin failures++;
         $display("FAIL lim_same_cycle: got %b want 0000", bank_arready); end
      cyc();
      rd_done_valid = 1'b0;
      #1;
      checks++; if (outs_cnt[3] !== 4'd7) begin failures++;
         $display("FAIL lim_cnt_dec: got %0d want 7", outs_cnt[3]); end
      checks++; if (bank_arready !== 4'b1000) begin failures++;
         $display("FAIL lim_regrant: got %b want 1000", bank_arready); end
      exp_q.push_back(mk_ar(3, 8));
      cyc();
      bank_arvalid = '0;
      #1;
      checks++; if (outs_cnt[3] !== 4'd8) begin failures++;
         $display("FAIL lim_cnt_refull: got %0d want 8", outs_cnt[3]); end
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_ar !== want) begin failures++;
         $display("FAIL lim_payload_re: got %h want %h", l2_ar, want); end
      cyc();
   endtask

   task automatic test_inc_dec();
      logic [AW-1:0] want;
      reset_dut();
      l2_arready   = 1'b1;
      bank_arvalid = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         bank_ar[1] = mk_ar(1, 20 + k);
         if (k == 5) begin
            rd_done_valid = 1'b1;
            rd_done_bank  = 2'd1;
         end
         #1;
         checks++; if (bank_arready !== 4'b0010) begin failures++;
            $display("FAIL incdec_grant[%0d]: got %b want 0010", k, bank_arready); end
         exp_q.push_back(mk_ar(1, 20 + k));
         if (k > 0) begin
            if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
            checks++; if (l2_ar !== want) begin failures++;
               $display("FAIL incdec_payload[%0d]: got %h want %h", k, l2_ar, want); end
         end
         cyc();
      end
      bank_arvalid  = '0;
      rd_done_valid = 1'b0;
      #1;
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_ar !== want) begin failures++;
         $display("FAIL incdec_payload_last: got %h want %h", l2_ar, want); end
      checks++; if (outs_cnt[1] !== 4'd5) begin failures++;
         $display("FAIL incdec_hold: got %0d want 5", outs_cnt[1]); end
      rd_done_valid = 1'b1;
      rd_done_bank  = 2'd0;
      cyc();
      rd_done_valid = 1'b0;
      #1;
      checks++; if (outs_cnt[0] !== 4'd0) begin failures++;
         $display("FAIL underflow_sat: got %0d want 0", outs_cnt[0]); end
      checks++; if (outs_cnt[1] !== 4'd5) begin failures++;
         $display("FAIL underflow_other: got %0d want 5", outs_cnt[1]); end
   endtask

   task automatic test_async_reset();
      logic [AW-1:0] want;
      logic [3:0]    vt [6];
      int            gt [6];
      vt = '{4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b1000, 4'b1000};
      gt = '{0, 1, 3, 0, 3, 3};
      reset_dut();
      l2_arready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         bank_arvalid = vt[k];
         for (int b = 0; b < NB; b++) bank_ar[b] = mk_ar(b, 30 + k);
         #1;
         checks++; if (bank_arready !== 4'(1 << gt[k])) begin failures++;
            $display("FAIL ar_setup_grant[%0d]: got %b want %b", k, bank_arready,
                     4'(1 << gt[k])); end
         exp_q.push_back(mk_ar(gt[k], 30 + k));
         if (k > 0) begin
            if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
            checks++; if (l2_ar !== want) begin failures++;
               $display("FAIL ar_setup_payload[%0d]: got %h want %h", k, l2_ar, want); end
         end
         cyc();
      end
      bank_arvalid = '0;
      l2_arready   = 1'b0;
      #1;
      checks++; if (l2_arvalid !== 1'b1) begin failures++;
         $display("FAIL ar_stalled: got %b want 1", l2_arvalid); end
      checks++; if (outs_cnt !== {4'd3, 4'd0, 4'd1, 4'd2}) begin failures++;
         $display("FAIL ar_pre_counts: got %h want 3012", outs_cnt); end
      rst = 1'b0;
      #1;
      checks++; if (l2_arvalid !== 1'b0 || l2_ar !== '0) begin failures++;
         $display("FAIL ar_async_stage: got %b/%h want 0/0", l2_arvalid, l2_ar); end
      checks++; if (outs_cnt !== '0) begin failures++;
         $display("FAIL ar_async_cnt: got %h want 0", outs_cnt); end
      exp_q.delete();
      #3;
      rst = 1'b1;
      cyc();
      bank_arvalid = '1;
      l2_arready   = 1'b1;
      for (int b = 0; b < NB; b++) bank_ar[b] = mk_ar(b, 40);
      #1;
      checks++; if (bank_arready !== 4'b0001) begin failures++;
         $display("FAIL ar_first_grant: got %b want 0001", bank_arready); end
      checks++; if (l2_arvalid !== 1'b0) begin failures++;
         $display("FAIL ar_no_replay: got %b want 0", l2_arvalid); end
      exp_q.push_back(mk_ar(0, 40));
      cyc();
      bank_arvalid = '0;
      #1;
      if (exp_q.size() != 0) want = exp_q.pop_front(); else want = 'x;
      checks++; if (l2_arvalid !== 1'b1 || l2_ar !== want) begin failures++;
         $display("FAIL ar_post_payload: got %b/%h want 1/%h", l2_arvalid, l2_ar, want); end
      checks++; if (outs_cnt !== {4'd0, 4'd0, 4'd0, 4'd1}) begin failures++;
         $display("FAIL ar_post_counts: got %h want 0001", outs_cnt); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_outstanding_limit();
      test_inc_dec();
      test_async_reset();
      checks++; if (exp_q.size() != 0) begin failures++;
         $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
